// File: rtl/dyn_clk_div.sv
// Run-time programmable clock divider: divided clock plus period strobe, ratio
// changed by req/ack at period boundaries. Define DYN_CLK_DIV_RAMP_EN for stepwise ramping.
module dyn_clk_div #(
    parameter int DIV_W     = 8,
    parameter int RST_DIV   = 4,
    parameter int RAMP_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [DIV_W-1:0] div_val,
    output logic             ack,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] cur_div,
    output logic             div_clk,
    output logic             tick
);
    localparam logic [DIV_W-1:0] RST_D  = DIV_W'(RST_DIV);
    localparam logic [DIV_W:0]   STEP_W = (DIV_W+1)'(RAMP_STEP);

    logic [DIV_W-1:0] tgt, p, p_inc, nxt_div;
    logic [DIV_W:0]   half;
    logic             bnd, accept;

`ifndef DYN_CLK_DIV_RAMP_EN
    logic unused_step;
    assign unused_step = ^STEP_W;
`endif

    always_comb begin
        bnd     = (cur_div == '0) || (p == cur_div - 1'b1);
        accept  = req && !busy;
        p_inc   = p + 1'b1;
        half    = ({1'b0, cur_div} + 1'b1) >> 1;
        nxt_div = cur_div;
        // Only a target accepted before this edge may move the ratio.
        if (busy) begin
`ifdef DYN_CLK_DIV_RAMP_EN
            if (cur_div == '0 || tgt == '0)
                nxt_div = tgt;
            else if (cur_div < tgt)
                nxt_div = ({1'b0, tgt - cur_div} > STEP_W) ? cur_div + STEP_W[DIV_W-1:0] : tgt;
            else
                nxt_div = ({1'b0, cur_div - tgt} > STEP_W) ? cur_div - STEP_W[DIV_W-1:0] : tgt;
`else
            nxt_div = tgt;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_div <= RST_D;
            tgt     <= RST_D;
            p       <= RST_D - 1'b1;
            ack     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            tick    <= 1'b0;
            div_clk <= 1'b0;
        end else begin
            ack  <= accept;
            done <= 1'b0;
            if (accept) begin
                tgt  <= div_val;
                busy <= 1'b1;
            end
            if (bnd) begin
                cur_div <= nxt_div;
                p       <= '0;
                tick    <= (nxt_div != '0);
                div_clk <= (nxt_div != '0);
                if (busy && nxt_div == tgt) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else begin
                p       <= p_inc;
                tick    <= 1'b0;
                div_clk <= ({1'b0, p_inc} < half);
            end
        end
    end
endmodule
